// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if -- raster timing bundle between the VGA timing generator
// and its consumers (color mapper, sprite/motion logic, VGA DAC pins).
interface vga_timing_gen_if;
    logic        VGA_CLK;
    logic        VGA_HS;
    logic        VGA_VS;
    logic        VGA_BLANK_N;
    logic        VGA_SYNC_N;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic        frame_clk;
    logic        frame_start;
    logic [15:0] frame_count;

    // Timing generator side
    modport master (
        output VGA_CLK,
        output VGA_HS,
        output VGA_VS,
        output VGA_BLANK_N,
        output VGA_SYNC_N,
        output DrawX,
        output DrawY,
        output frame_clk,
        output frame_start,
        output frame_count
    );

    // Consumer side
    modport slave (
        input VGA_CLK,
        input VGA_HS,
        input VGA_VS,
        input VGA_BLANK_N,
        input VGA_SYNC_N,
        input DrawX,
        input DrawY,
        input frame_clk,
        input frame_start,
        input frame_count
    );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen -- VGA raster timing from the system clock.
// Produces pixel coordinates for the color mapper, a pixel clock, and
// sync/blank outputs delayed by SYNC_DELAY Clk cycles so they line up with
// the registered colour path. Also provides the per-frame tick signals.
module vga_timing_gen #(
    parameter int H_VISIBLE  = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int PIX_DIV    = 2,
    parameter int SYNC_DELAY = 2
) (
    input  logic             Clk,
    input  logic             Reset_n,
    vga_timing_gen_if.master vga
);
    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = $clog2(PIX_DIV);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(PIX_DIV / 2);

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
    localparam logic [9:0] HS_BEG = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] HS_END = 10'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] VS_END = 10'(V_VISIBLE + V_FP + V_SYNC);

    logic [DIV_W-1:0] div_cnt;
    logic             pix_en;
    logic             h_last;
    logic             v_last;
    logic             frame_wrap;
    logic [9:0]       hc;
    logic [9:0]       vc;
    logic             hs_p0;
    logic             vs_p0;
    logic             blank_n_p0;
    logic             frame_start;
    logic [15:0]      frame_count;

    assign pix_en     = (div_cnt == DIV_LAST);
    assign h_last     = (hc == H_LAST);
    assign v_last     = (vc == V_LAST);
    // Last pixel of the last line: the next pixel edge starts a new frame
    assign frame_wrap = pix_en && h_last && v_last;

    // Clk divider; pix_en marks the final Clk of each pixel period
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            div_cnt <= '0;
        end else if (pix_en) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Horizontal pixel counter, one step per pixel period
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            hc <= '0;
        end else if (pix_en) begin
            hc <= h_last ? 10'd0 : hc + 10'd1;
        end
    end

    // Vertical line counter, advances on the same edge that wraps hc
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            vc <= '0;
        end else if (pix_en && h_last) begin
            vc <= v_last ? 10'd0 : vc + 10'd1;
        end
    end

    // ---- stage p0: raw sync/blank decoded straight from the counters ----
    assign hs_p0      = !((hc >= HS_BEG) && (hc < HS_END));
    assign vs_p0      = !((vc >= VS_BEG) && (vc < VS_END));
    assign blank_n_p0 = (hc < H_VIS) && (vc < V_VIS);

    // Frame tick: pulse on the first Clk of the new frame, count frames
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            frame_start <= 1'b0;
            frame_count <= '0;
        end else begin
            frame_start <= frame_wrap;
            if (frame_wrap) begin
                frame_count <= frame_count + 16'd1;
            end
        end
    end

    // Coordinates and undelayed frame signals
    assign vga.DrawX       = hc;
    assign vga.DrawY       = vc;
    assign vga.VGA_CLK     = (div_cnt >= DIV_HALF);
    assign vga.VGA_SYNC_N  = 1'b0;
    assign vga.frame_clk   = vs_p0;
    assign vga.frame_start = frame_start;
    assign vga.frame_count = frame_count;

    // ---- stages p1..pN: sync/blank delay matching the colour pipeline ----
    generate
        if (SYNC_DELAY == 0) begin : g_no_delay
            assign vga.VGA_HS      = hs_p0;
            assign vga.VGA_VS      = vs_p0;
            assign vga.VGA_BLANK_N = blank_n_p0;
        end else begin : g_delay
            logic [SYNC_DELAY-1:0] hs_pn;
            logic [SYNC_DELAY-1:0] vs_pn;
            logic [SYNC_DELAY-1:0] blank_n_pn;

            // Shift raw sync/blank through SYNC_DELAY stages, reset to inactive
            always_ff @(posedge Clk or negedge Reset_n) begin
                if (!Reset_n) begin
                    hs_pn      <= '1;
                    vs_pn      <= '1;
                    blank_n_pn <= '0;
                end else begin
                    hs_pn      <= SYNC_DELAY'({hs_pn, hs_p0});
                    vs_pn      <= SYNC_DELAY'({vs_pn, vs_p0});
                    blank_n_pn <= SYNC_DELAY'({blank_n_pn, blank_n_p0});
                end
            end

            assign vga.VGA_HS      = hs_pn[SYNC_DELAY-1];
            assign vga.VGA_VS      = vs_pn[SYNC_DELAY-1];
            assign vga.VGA_BLANK_N = blank_n_pn[SYNC_DELAY-1];
        end
    endgenerate
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen -- scoreboard bench for vga_timing_gen.
// Three instances: default timing (SYNC_DELAY=2), default timing with
// SYNC_DELAY=0, and a shrunken raster (30x17 totals) so whole frames and a
// mid-frame reset fit in a short run. Stimulus pushes expected edge events
// and point-in-time values; a negedge monitor pops and compares.
module tb_vga_timing_gen;
    localparam int NSIG = 7;
    localparam int FS   = 6;
    localparam int NCHK = 19;

    typedef struct {
        longint cyc;
        logic   val;
        int     cnt;
    } ev_t;

    typedef struct {
        longint cyc;
        int     id;
        int     expv;
    } chk_t;

    logic   Clk;
    logic   rst_n;
    logic   rst_n_s;
    longint cyc = 0;

    vga_timing_gen_if f_if ();
    vga_timing_gen_if n_if ();
    vga_timing_gen_if s_if ();

    vga_timing_gen dut_f (
        .Clk     (Clk),
        .Reset_n (rst_n),
        .vga     (f_if)
    );

    vga_timing_gen #(
        .SYNC_DELAY (0)
    ) dut_n (
        .Clk     (Clk),
        .Reset_n (rst_n),
        .vga     (n_if)
    );

    vga_timing_gen #(
        .H_VISIBLE (16),
        .H_FP      (4),
        .H_SYNC    (6),
        .H_BP      (4),
        .V_VISIBLE (10),
        .V_FP      (2),
        .V_SYNC    (2),
        .V_BP      (3)
    ) dut_s (
        .Clk     (Clk),
        .Reset_n (rst_n_s),
        .vga     (s_if)
    );

    // Scoreboard state
    ev_t             evq [NSIG][$];
    chk_t            chk_q [$];
    logic [NSIG-1:0] mon_en;
    bit              done;
    bit              timeout_err;
    longint          rel_s;

    // Monitor-owned state
    int              n_cmp = 0;
    int              n_bad = 0;
    int              viol  = 0;
    int              n_win = 0;
    logic [NSIG-1:0] cur;
    logic [NSIG-1:0] prev;
    ev_t             ev;
    chk_t            ck;
    int              act;
    logic [9:0]      xh1, xh2, yh1, yh2;

    string sig_nm [NSIG] = '{"f_VGA_HS", "f_VGA_BLANK_N", "n_VGA_HS", "n_VGA_BLANK_N",
                             "s_VGA_VS", "s_frame_clk", "s_frame_start"};
    string chk_nm [NCHK] = '{"f_DrawX", "f_DrawY", "f_VGA_HS", "f_VGA_VS", "f_VGA_BLANK_N",
                             "f_VGA_SYNC_N", "f_frame_count", "f_VGA_CLK", "f_frame_clk",
                             "f_frame_start", "s_DrawX", "s_DrawY", "s_VGA_HS", "s_VGA_VS",
                             "s_VGA_BLANK_N", "s_frame_count", "s_frame_start", "s_frame_clk",
                             "n_VGA_SYNC_N"};

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    always @(posedge Clk) cyc <= cyc + 1;

    initial begin
        #600000;
        $display("FAIL watchdog: time limit reached at cycle %0d, required normal end", cyc);
        $fatal(1, "watchdog");
    end

    function automatic int probe(input int id);
        case (id)
            0:  return int'(f_if.DrawX);
            1:  return int'(f_if.DrawY);
            2:  return int'(f_if.VGA_HS);
            3:  return int'(f_if.VGA_VS);
            4:  return int'(f_if.VGA_BLANK_N);
            5:  return int'(f_if.VGA_SYNC_N);
            6:  return int'(f_if.frame_count);
            7:  return int'(f_if.VGA_CLK);
            8:  return int'(f_if.frame_clk);
            9:  return int'(f_if.frame_start);
            10: return int'(s_if.DrawX);
            11: return int'(s_if.DrawY);
            12: return int'(s_if.VGA_HS);
            13: return int'(s_if.VGA_VS);
            14: return int'(s_if.VGA_BLANK_N);
            15: return int'(s_if.frame_count);
            16: return int'(s_if.frame_start);
            17: return int'(s_if.frame_clk);
            default: return int'(n_if.VGA_SYNC_N);
        endcase
    endfunction

    task automatic push_ev(input int i, input longint c, input logic v, input int n);
        ev_t e;
        e.cyc = c;
        e.val = v;
        e.cnt = n;
        evq[i].push_back(e);
    endtask

    task automatic push_chk(input longint c, input int id, input int expv);
        chk_t k;
        k.cyc  = c;
        k.id   = id;
        k.expv = expv;
        chk_q.push_back(k);
    endtask

    task automatic wait_until(input longint t);
        while (cyc < t) begin
            @(posedge Clk);
            #2;
        end
    endtask

    // Monitor: edge events, timed point checks, sync/blank window model
    always @(negedge Clk) begin
        cur = {s_if.frame_start, s_if.frame_clk, s_if.VGA_VS, n_if.VGA_BLANK_N,
               n_if.VGA_HS, f_if.VGA_BLANK_N, f_if.VGA_HS};
        for (int i = 0; i < NSIG; i++) begin
            if (mon_en[i[2:0]] && (cur[i[2:0]] !== prev[i[2:0]]) &&
                !(i == FS && cur[i[2:0]] == 1'b0)) begin
                n_cmp++;
                if (evq[i].size() == 0) begin
                    n_bad++;
                    $display("FAIL %s: edge to %b at cycle %0d, required no edge", sig_nm[i],
                             cur[i[2:0]], cyc);
                end else begin
                    ev = evq[i].pop_front();
                    if (ev.cyc != cyc || ev.val !== cur[i[2:0]]) begin
                        n_bad++;
                        $display("FAIL %s: edge to %b at cycle %0d, required edge to %b at cycle %0d",
                                 sig_nm[i], cur[i[2:0]], cyc, ev.val, ev.cyc);
                    end
                    if (i == FS) begin
                        n_cmp++;
                        if (s_if.frame_count !== 16'(ev.cnt)) begin
                            n_bad++;
                            $display("FAIL s_frame_count at frame_start: got %0d, required %0d",
                                     s_if.frame_count, ev.cnt);
                        end
                    end
                end
            end
        end
        prev = cur;

        while (chk_q.size() > 0 && chk_q[0].cyc <= cyc) begin
            ck = chk_q.pop_front();
            n_cmp++;
            if (ck.cyc != cyc) begin
                n_bad++;
                $display("FAIL %s: check at cycle %0d skipped (now %0d), required on time",
                         chk_nm[ck.id], ck.cyc, cyc);
            end else begin
                act = probe(ck.id);
                if (act != ck.expv) begin
                    n_bad++;
                    $display("FAIL %s @cycle %0d: got %0d, required %0d", chk_nm[ck.id], cyc,
                             act, ck.expv);
                end
            end
        end

        // Small raster: delayed outputs must match coordinates seen 2 Clk earlier
        if (rst_n_s === 1'b1 && cyc >= rel_s + 2) begin
            n_win++;
            if (s_if.VGA_BLANK_N !== ((xh2 < 10'd16) && (yh2 < 10'd10))) viol++;
            if (s_if.VGA_HS !== !((xh2 >= 10'd20) && (xh2 < 10'd26))) viol++;
            if (s_if.VGA_VS !== !((yh2 >= 10'd12) && (yh2 < 10'd14))) viol++;
        end
        xh2 = xh1;
        xh1 = s_if.DrawX;
        yh2 = yh1;
        yh1 = s_if.DrawY;

        if (done) begin
            for (int i = 0; i < NSIG; i++) begin
                n_cmp++;
                if (evq[i].size() != 0) begin
                    n_bad++;
                    $display("FAIL %s: %0d edges never seen (next due cycle %0d), required 0",
                             sig_nm[i], evq[i].size(), evq[i][0].cyc);
                end
            end
            n_cmp++;
            if (chk_q.size() != 0) begin
                n_bad++;
                $display("FAIL pending_checks: got %0d left, required 0", chk_q.size());
            end
            n_cmp++;
            if (viol != 0) begin
                n_bad++;
                $display("FAIL s_sync_blank_window: got %0d violations, required 0", viol);
            end
            n_cmp++;
            if (n_win < 1000) begin
                n_bad++;
                $display("FAIL s_window_coverage: got %0d cycles, required >= 1000", n_win);
            end
            n_cmp++;
            if (timeout_err) begin
                n_bad++;
                $display("FAIL mid_frame_wait: got timeout, required DrawX=20 DrawY=5 reached");
            end
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
            $finish;
        end
    end

    // Stimulus
    initial begin
        longint c;
        longint r;
        longint r2;
        bit     found;

        rst_n       = 1'b0;
        rst_n_s     = 1'b0;
        mon_en      = '0;
        done        = 1'b0;
        timeout_err = 1'b0;
        rel_s       = 0;

        repeat (4) @(posedge Clk);
        #2;
        // Reset values, full-size instance and the others' constant pin
        c = cyc;
        push_chk(c, 0, 0);
        push_chk(c, 1, 0);
        push_chk(c, 2, 1);
        push_chk(c, 3, 1);
        push_chk(c, 4, 0);
        push_chk(c, 5, 0);
        push_chk(c, 6, 0);
        push_chk(c, 7, 0);
        push_chk(c, 8, 1);
        push_chk(c, 9, 0);
        push_chk(c, 13, 1);
        push_chk(c, 14, 0);
        push_chk(c, 18, 0);
        mon_en = '1;

        @(posedge Clk);
        #2;
        r     = cyc;
        rel_s = r;
        // Full-size, SYNC_DELAY=2: HS low 656..751 -> +2 Clk, line 1600 Clk
        push_ev(0, r + 1314, 1'b0, 0);
        push_ev(0, r + 1506, 1'b1, 0);
        push_ev(0, r + 2914, 1'b0, 0);
        push_ev(0, r + 3106, 1'b1, 0);
        push_ev(1, r + 2,    1'b1, 0);
        push_ev(1, r + 1282, 1'b0, 0);
        push_ev(1, r + 1602, 1'b1, 0);
        push_ev(1, r + 2882, 1'b0, 0);
        // Full-size, SYNC_DELAY=0: edges coincide with the DrawX change
        push_ev(2, r + 1312, 1'b0, 0);
        push_ev(2, r + 1504, 1'b1, 0);
        push_ev(2, r + 2912, 1'b0, 0);
        push_ev(2, r + 3104, 1'b1, 0);
        push_ev(3, r + 1280, 1'b0, 0);
        push_ev(3, r + 1600, 1'b1, 0);
        push_ev(3, r + 2880, 1'b0, 0);
        // Small raster: line 60 Clk, frame 1020 Clk, VS lines 12..13
        for (int k = 0; k < 3; k++) begin
            push_ev(4, r + 722 + 1020 * k, 1'b0, 0);
            push_ev(4, r + 842 + 1020 * k, 1'b1, 0);
            push_ev(5, r + 720 + 1020 * k, 1'b0, 0);
            push_ev(5, r + 840 + 1020 * k, 1'b1, 0);
            push_ev(FS, r + 1020 * (k + 1), 1'b1, k + 1);
        end
        push_chk(r + 1,    0, 0);
        push_chk(r + 1,    7, 1);
        push_chk(r + 2,    0, 1);
        push_chk(r + 2,    1, 0);
        push_chk(r + 2,    7, 0);
        push_chk(r + 1019, 15, 0);
        push_chk(r + 1020, 10, 0);
        push_chk(r + 1020, 11, 0);
        push_chk(r + 1311, 0, 655);
        push_chk(r + 1312, 0, 656);
        push_chk(r + 1312, 2, 1);
        push_chk(r + 1599, 0, 799);
        push_chk(r + 1599, 1, 0);
        push_chk(r + 1600, 0, 0);
        push_chk(r + 1600, 1, 1);
        rst_n   = 1'b1;
        rst_n_s = 1'b1;

        wait_until(r + 3150);
        mon_en[3:0] = 4'b0000;

        // Mid-frame reset on the small raster at DrawX=20, DrawY=5
        found = 1'b0;
        for (int k = 0; k < 3000 && !found; k++) begin
            @(posedge Clk);
            #2;
            if (s_if.DrawX == 10'd20 && s_if.DrawY == 10'd5) found = 1'b1;
        end
        if (!found) begin
            timeout_err = 1'b1;
        end else begin
            rst_n_s = 1'b0;
            c = cyc;
            push_chk(c, 10, 0);
            push_chk(c, 11, 0);
            push_chk(c, 12, 1);
            push_chk(c, 13, 1);
            push_chk(c, 14, 0);
            push_chk(c, 15, 0);
            push_chk(c, 16, 0);
            push_chk(c, 17, 1);
            repeat (3) @(posedge Clk);
            #2;
            r2    = cyc;
            rel_s = r2;
            push_ev(4, r2 + 722, 1'b0, 0);
            push_ev(4, r2 + 842, 1'b1, 0);
            push_ev(5, r2 + 720, 1'b0, 0);
            push_ev(5, r2 + 840, 1'b1, 0);
            push_ev(FS, r2 + 1020, 1'b1, 1);
            push_chk(r2 + 2,    10, 1);
            push_chk(r2 + 2,    11, 0);
            push_chk(r2 + 1019, 15, 0);
            push_chk(r2 + 1020, 10, 0);
            push_chk(r2 + 1020, 11, 0);
            rst_n_s = 1'b1;
            wait_until(r2 + 1100);
        end
        done = 1'b1;
    end
endmodule
